// File: rtl/seq_alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, FSM states and status bit positions.
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_SHIFT = 3'b010;
    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_DIV   = 3'b100;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam int unsigned STAT_C   = 0;
    localparam int unsigned STAT_Z   = 1;
    localparam int unsigned STAT_N   = 2;
    localparam int unsigned STAT_V   = 3;
    localparam int unsigned STAT_ERR = 4;
    localparam int unsigned STAT_W   = 5;

    // Assemble the status word from individual flags.
    function automatic logic [STAT_W-1:0] make_status(input logic err, input logic v,
                                                      input logic n, input logic z,
                                                      input logic c);
        logic [STAT_W-1:0] st;
        st           = '0;
        st[STAT_C]   = c;
        st[STAT_Z]   = z;
        st[STAT_N]   = n;
        st[STAT_V]   = v;
        st[STAT_ERR] = err;
        return st;
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bus of the sequential ALU.
interface seq_alu_if #(parameter int unsigned WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic [4:0]       status_out;

    modport slave (
        input  in_valid, opcode, operand1, operand2, carry_in, out_ready,
        output in_ready, out_valid, result_hi, result_lo, status_out
    );

    modport master (
        output in_valid, opcode, operand1, operand2, carry_in, out_ready,
        input  in_ready, out_valid, result_hi, result_lo, status_out
    );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per clock.
module seq_alu_muldiv #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_c,
    output logic [WIDTH-1:0] hi_c,
    output logic [WIDTH-1:0] lo_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic             busy_q, busy_d;
    logic             div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;

    // hi/lo hold partial product (MUL) or remainder/quotient (DIV); m is multiplicand or divisor.
    always_comb begin
        busy_d    = busy_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        m_d       = m_q;
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : (WIDTH+1)'(0));
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, m_q};
        done_c    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

        if (start) begin
            busy_d = 1'b1;
            div_d  = op_div;
            cnt_d  = '0;
            hi_d   = '0;
            lo_d   = op_div ? a : b;
            m_d    = op_div ? b : a;
        end else if (busy_q) begin
            if (div_q) begin
                // A set top bit means the trial subtraction borrowed: restore.
                if (!div_trial[WIDTH]) begin
                    hi_d = div_trial[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = div_shift[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi_d = mul_sum[WIDTH:1];
                lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (done_c) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    assign hi_c = hi_d;
    assign lo_c = lo_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            m_q    <= '0;
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            m_q    <= m_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ADD/SUB/SHIFT, iterative MUL/DIV, valid/ready handshake.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    seq_alu_if.slave bus
);

    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [STAT_W-1:0] status_q, status_d;
    logic              div_q, div_d;

    logic              md_start;
    logic              md_done_c;
    logic [WIDTH-1:0]  md_hi;
    logic [WIDTH-1:0]  md_lo;
    logic              iter_op;

    logic [WIDTH:0]    add_w;
    logic [WIDTH:0]    sub_w;
    logic [WIDTH:0]    sh_mag;
    logic [WIDTH-1:0]  sh_res;
    logic [WIDTH-1:0]  alu_hi;
    logic [WIDTH-1:0]  alu_lo;
    logic              alu_c, alu_v, alu_err, alu_illegal;
    logic [STAT_W-1:0] alu_st;

    assign iter_op = (bus.opcode == OP_MUL) ||
                     ((bus.opcode == OP_DIV) && (bus.operand2 != '0));

    // Single-cycle results, evaluated on the live request and captured at accept.
    always_comb begin
        alu_hi      = '0;
        alu_lo      = '0;
        alu_c       = 1'b0;
        alu_v       = 1'b0;
        alu_err     = 1'b0;
        alu_illegal = 1'b0;
        add_w  = {1'b0, bus.operand1} + {1'b0, bus.operand2} + (WIDTH+1)'(bus.carry_in);
        sub_w  = {1'b0, bus.operand1} - {1'b0, bus.operand2} - (WIDTH+1)'(bus.carry_in);
        sh_mag = bus.operand2[WIDTH-1] ?
                 ((WIDTH+1)'(0) - {bus.operand2[WIDTH-1], bus.operand2}) :
                 {1'b0, bus.operand2};
        if (sh_mag >= (WIDTH+1)'(WIDTH))
            sh_res = '0;
        else if (bus.operand2[WIDTH-1])
            sh_res = bus.operand1 << sh_mag;
        else
            sh_res = bus.operand1 >> sh_mag;

        case (bus.opcode)
            OP_ADD: begin
                alu_lo = add_w[WIDTH-1:0];
                alu_c  = add_w[WIDTH];
                alu_v  = (bus.operand1[WIDTH-1] == bus.operand2[WIDTH-1]) &&
                         (alu_lo[WIDTH-1] != bus.operand1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_lo = sub_w[WIDTH-1:0];
                alu_c  = sub_w[WIDTH];
                alu_v  = (bus.operand1[WIDTH-1] != bus.operand2[WIDTH-1]) &&
                         (alu_lo[WIDTH-1] != bus.operand1[WIDTH-1]);
            end
            OP_SHIFT: alu_lo = sh_res;
            OP_MUL:   alu_lo = '0;
            OP_DIV: begin
                // Only reached for a zero divisor; nonzero divisors go iterative.
                alu_lo  = '1;
                alu_hi  = bus.operand1;
                alu_err = 1'b1;
            end
            default: begin
                alu_err     = 1'b1;
                alu_illegal = 1'b1;
            end
        endcase

        alu_st = make_status(alu_err, alu_v,
                             !alu_illegal && alu_lo[WIDTH-1],
                             !alu_illegal && (alu_hi == '0) && (alu_lo == '0),
                             alu_c);
    end

    // FSM next-state and result capture.
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        status_d = status_q;
        div_d    = div_q;
        md_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (iter_op) begin
                        md_start = 1'b1;
                        div_d    = (bus.opcode == OP_DIV);
                        state_d  = ST_BUSY;
                    end else begin
                        hi_d     = alu_hi;
                        lo_d     = alu_lo;
                        status_d = alu_st;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                if (md_done_c) begin
                    hi_d     = md_hi;
                    lo_d     = md_lo;
                    status_d = make_status(1'b0, 1'b0,
                                           div_q ? md_lo[WIDTH-1] : md_hi[WIDTH-1],
                                           (md_hi == '0) && (md_lo == '0),
                                           !div_q && (md_hi != '0));
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            status_q <= '0;
            div_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            status_q <= status_d;
            div_q    <= div_d;
        end
    end

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .op_div (bus.opcode == OP_DIV),
        .a      (bus.operand1),
        .b      (bus.operand2),
        .done_c (md_done_c),
        .hi_c   (md_hi),
        .lo_c   (md_lo)
    );

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.result_hi  = hi_q;
    assign bus.result_lo  = lo_q;
    assign bus.status_out = status_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner vectors plus randomized ops against an arithmetic model.
module tb_seq_alu;

    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint sx(input logic [W-1:0] x);
        longint m = longint'(1) << W;
        return (longint'(x) >= m / 2) ? longint'(x) - m : longint'(x);
    endfunction

    // Arithmetic reference model; lat counts edges from the accept edge (inclusive) to out_valid.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, output logic [W-1:0] hi, output logic [W-1:0] lo,
                                  output logic [4:0] st, output int lat);
        longint m  = longint'(1) << W;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint r, sr, s;
        logic c = 0, v = 0, n, z, e = 0;
        hi = '0; lo = '0; lat = 1;
        case (op)
            3'd0: begin
                r = ua + ub + longint'(cin); lo = W'(r); c = (r >= m);
                sr = sx(a) + sx(b) + longint'(cin); v = (sr > m/2 - 1) || (sr < -m/2);
            end
            3'd1: begin
                r = ua - ub - longint'(cin); lo = W'(r); c = (r < 0);
                sr = sx(a) - sx(b) - longint'(cin); v = (sr > m/2 - 1) || (sr < -m/2);
            end
            3'd2: begin
                s = sx(b);
                if (s >= longint'(W) || -s >= longint'(W)) lo = '0;
                else if (s > 0) lo = W'(ua >> s);
                else lo = W'(ua << (-s));
            end
            3'd3: begin
                r = ua * ub; hi = W'(r >> W); lo = W'(r); c = (hi != 0); lat = W + 1;
            end
            3'd4: begin
                if (ub == 0) begin lo = '1; hi = a; e = 1; end
                else begin lo = W'(ua / ub); hi = W'(ua % ub); lat = W + 1; end
            end
            default: e = 1;
        endcase
        n = (op == 3'd3) ? hi[W-1] : lo[W-1];
        z = (hi == 0) && (lo == 0);
        if (op > 3'd4) begin n = 0; z = 0; end
        st = {e, v, n, z, c};
    endfunction

    // Issue one request and collect the response; inputs are scrambled while it is in flight.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, output logic [W-1:0] hi, output logic [W-1:0] lo,
                         output logic [4:0] st, output int lat, output int busy, output bit tmo);
        int guard = 0;
        hi = '0; lo = '0; st = '0; lat = 0; busy = 0; tmo = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin @(negedge clk); guard++; end
        if (!bus.in_ready) begin tmo = 1; return; end
        bus.opcode = op; bus.operand1 = a; bus.operand2 = b; bus.carry_in = cin;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            if (!bus.in_ready) busy++;
            bus.opcode = 3'($urandom); bus.operand1 = W'($urandom);
            bus.operand2 = W'($urandom); bus.carry_in = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) begin tmo = 1; return; end
        hi = bus.result_hi; lo = bus.result_lo; st = bus.status_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_handshake: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
        n_cmp++;
        if (bus.result_hi !== '0 || bus.result_lo !== '0 || bus.status_out !== 5'b0) begin
            n_bad++; $display("FAIL reset_outputs: hi=%h lo=%h st=%b want 0", bus.result_hi, bus.result_lo, bus.status_out);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_release_ready: in_ready=%b want 1", bus.in_ready);
        end
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b;
        logic         cin;
        logic [W-1:0] hi, lo;
        logic [4:0]   st;
        int           lat;
    } vec_t;

    task automatic test_directed();
        vec_t v[12];
        logic [W-1:0] hi, lo;
        logic [4:0] st;
        int lat, busy;
        bit tmo;
        v[0]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 5'b00011, 1};
        v[1]  = '{3'd1, 8'h80, 8'h01, 1'b0, 8'h00, 8'h7F, 5'b01000, 1};
        v[2]  = '{3'd3, 8'hFF, 8'hFF, 1'b0, 8'hFE, 8'h01, 5'b00101, 9};
        v[3]  = '{3'd4, 8'd100, 8'd7, 1'b0, 8'd2, 8'd14, 5'b00000, 9};
        v[4]  = '{3'd4, 8'd5, 8'd0, 1'b0, 8'h05, 8'hFF, 5'b10100, 1};
        v[5]  = '{3'd2, 8'h81, 8'h01, 1'b0, 8'h00, 8'h40, 5'b00000, 1};
        v[6]  = '{3'd2, 8'h81, 8'hFF, 1'b0, 8'h00, 8'h02, 5'b00000, 1};
        v[7]  = '{3'd2, 8'h81, 8'hF8, 1'b0, 8'h00, 8'h00, 5'b00010, 1};
        v[8]  = '{3'd7, 8'h12, 8'h34, 1'b1, 8'h00, 8'h00, 5'b10000, 1};
        v[9]  = '{3'd2, 8'h81, 8'h00, 1'b0, 8'h00, 8'h81, 5'b00100, 1};
        v[10] = '{3'd1, 8'h00, 8'h00, 1'b1, 8'h00, 8'hFF, 5'b00101, 1};
        v[11] = '{3'd0, 8'h7F, 8'h00, 1'b1, 8'h00, 8'h80, 5'b01100, 1};
        for (int i = 0; i < 12; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, v[i].cin, hi, lo, st, lat, busy, tmo);
            n_cmp++;
            if (tmo) begin n_bad++; $display("FAIL dir%0d_timeout: no response", i); continue; end
            n_cmp++;
            if (hi !== v[i].hi || lo !== v[i].lo) begin
                n_bad++; $display("FAIL dir%0d_result: hi=%h lo=%h want %h %h", i, hi, lo, v[i].hi, v[i].lo);
            end
            n_cmp++;
            if (st !== v[i].st) begin
                n_bad++; $display("FAIL dir%0d_status: st=%b want %b", i, st, v[i].st);
            end
            n_cmp++;
            if (lat != v[i].lat) begin
                n_bad++; $display("FAIL dir%0d_latency: lat=%0d want %0d", i, lat, v[i].lat);
            end
            if (v[i].op == 3'd3) begin
                n_cmp++;
                if (busy != 8) begin
                    n_bad++; $display("FAIL dir%0d_busy_cycles: in_ready low %0d want 8", i, busy);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [W-1:0] a, b, hi, lo, ehi, elo;
        logic [4:0] st, est;
        logic cin;
        int lat, elat, busy, r;
        bit tmo;
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            op = (r < 2) ? 3'd0 : (r < 4) ? 3'd1 : (r < 6) ? 3'd2 : (r == 6) ? 3'd3 :
                 (r < 9) ? 3'd4 : 3'($urandom_range(5, 7));
            a = W'($urandom); cin = 1'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            model(op, a, b, cin, ehi, elo, est, elat);
            do_op(op, a, b, cin, hi, lo, st, lat, busy, tmo);
            n_cmp++;
            if (tmo) begin n_bad++; $display("FAIL rnd%0d_timeout: op=%0d no response", i, op); continue; end
            n_cmp++;
            if (hi !== ehi || lo !== elo) begin
                n_bad++; $display("FAIL rnd%0d_result: op=%0d a=%h b=%h c=%b got %h_%h want %h_%h",
                                  i, op, a, b, cin, hi, lo, ehi, elo);
            end
            n_cmp++;
            if (st !== est) begin
                n_bad++; $display("FAIL rnd%0d_status: op=%0d a=%h b=%h c=%b got %b want %b", i, op, a, b, cin, st, est);
            end
            n_cmp++;
            if (lat != elat) begin
                n_bad++; $display("FAIL rnd%0d_latency: op=%0d got %0d want %0d", i, op, lat, elat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ehi, elo, hi0, lo0;
        logic [4:0] est, st0;
        int elat, guard = 0;
        model(3'd3, 8'hC3, 8'h5A, 1'b0, ehi, elo, est, elat);
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin @(negedge clk); guard++; end
        bus.out_ready = 1'b0;
        bus.opcode = 3'd3; bus.operand1 = 8'hC3; bus.operand2 = 8'h5A; bus.carry_in = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < 40) begin @(posedge clk); #1; guard++; end
        n_cmp++;
        if (!bus.out_valid) begin
            n_bad++; $display("FAIL bp_timeout: out_valid never rose");
        end
        hi0 = bus.result_hi; lo0 = bus.result_lo; st0 = bus.status_out;
        n_cmp++;
        if (hi0 !== ehi || lo0 !== elo || st0 !== est) begin
            n_bad++; $display("FAIL bp_result: got %h_%h %b want %h_%h %b", hi0, lo0, st0, ehi, elo, est);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.opcode = 3'd0;
            bus.operand1 = W'($urandom); bus.operand2 = W'($urandom);
            @(posedge clk); #1;
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result_hi !== hi0 ||
                bus.result_lo !== lo0 || bus.status_out !== st0) begin
                n_bad++; $display("FAIL bp_hold%0d: ov=%b rdy=%b %h_%h %b want 1 0 %h_%h %b", i, bus.out_valid,
                                  bus.in_ready, bus.result_hi, bus.result_lo, bus.status_out, hi0, lo0, st0);
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_release: ov=%b rdy=%b want 0 1 (no accept on release edge)",
                              bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] hi, lo;
        logic [4:0] st;
        int lat, busy, seen = 0, guard = 0;
        bit tmo;
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin @(negedge clk); guard++; end
        bus.opcode = 3'd3; bus.operand1 = 8'h9D; bus.operand2 = 8'h77; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL midrst_handshake: ov=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        n_cmp++;
        if (bus.result_hi !== '0 || bus.result_lo !== '0 || bus.status_out !== 5'b0) begin
            n_bad++; $display("FAIL midrst_outputs: %h_%h %b want 0", bus.result_hi, bus.result_lo, bus.status_out);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++; $display("FAIL midrst_no_result: out_valid seen %0d cycles want 0", seen);
        end
        do_op(3'd4, 8'd200, 8'd9, 1'b0, hi, lo, st, lat, busy, tmo);
        n_cmp++;
        if (tmo || hi !== 8'd2 || lo !== 8'd22 || lat != 9) begin
            n_bad++; $display("FAIL midrst_recover: tmo=%0d %h_%h lat=%0d want 02_16 lat 9", tmo, hi, lo, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ehi, elo;
        logic [4:0] est;
        int elat, nvalid = 0, nbad_lo = 0, guard = 0;
        model(3'd1, 8'h3C, 8'h5D, 1'b1, ehi, elo, est, elat);
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin @(negedge clk); guard++; end
        bus.opcode = 3'd1; bus.operand1 = 8'h3C; bus.operand2 = 8'h5D; bus.carry_in = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                nvalid++;
                if (bus.result_lo !== elo || bus.status_out !== est) nbad_lo++;
            end
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (nvalid != 5) begin
            n_bad++; $display("FAIL b2b_throughput: %0d results in 10 cycles want 5", nvalid);
        end
        n_cmp++;
        if (nbad_lo != 0) begin
            n_bad++; $display("FAIL b2b_result: %0d wrong results want 0 (expected lo %h st %b)", nbad_lo, elo, est);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.opcode    = 3'd0;
        bus.operand1  = '0;
        bus.operand2  = '0;
        bus.carry_in  = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits; legal range 4..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: in_valid  input  1  request valid.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: opcode  input  3  000 ADD, 001 SUB, 010 SHIFT, 011 MUL, 100 DIV; others illegal.
REQ-007 Port: operand1  input  WIDTH  A operand, dividend, or shift source.
REQ-008 Port: operand2  input  WIDTH  B operand, divisor, or signed shift amount.
REQ-009 Port: carry_in  input  1  carry for ADD; borrow for SUB; ignored otherwise.
REQ-010 Port: out_valid  output  1  result valid.
REQ-011 Port: out_ready  input  1  consumer takes result.
REQ-012 Port: result_hi  output  WIDTH  MUL upper half, DIV remainder, else 0.
REQ-013 Port: result_lo  output  WIDTH  ADD/SUB/SHIFT result, MUL lower half, DIV quotient.
REQ-014 Port: status_out  output  5  {err, v, n, z, c}.

Function
REQ-015 States IDLE, BUSY, DONE; in_ready SHALL equal (state==IDLE).
REQ-016 Accept = in_valid && in_ready on a rising edge; opcode, operands, carry_in captured then; later input changes ignored until next accept.
REQ-017 ADD/SUB/SHIFT/illegal/DIV-by-zero: IDLE->DONE at accept edge; out_valid high the cycle after accept (latency 1).
REQ-018 MUL/DIV (divisor!=0): IDLE->BUSY at accept; exactly WIDTH iteration edges; BUSY->DONE on the WIDTH-th; out_valid high the cycle after (latency WIDTH+1 edges from accept inclusive).
REQ-019 DONE->IDLE on edge with out_ready high; no accept in that same edge; result_*/status_out SHALL hold stable while out_valid && !out_ready.
REQ-020 ADD: {c,lo} = a+b+carry_in, unsigned width WIDTH+1; v = two's-complement overflow.
REQ-021 SUB: lo = a-b-carry_in mod 2^WIDTH; c = 1 on borrow; v = signed overflow.
REQ-022 SHIFT: operand2 signed; s>0 logical right by s; s<0 left by |s|; |s|>=WIDTH gives 0; s=0 passes; c=v=0.
REQ-023 MUL: unsigned shift-add, one partial product per cycle; {hi,lo}=a*b; c = (hi!=0); v=0.
REQ-024 DIV: unsigned restoring, one quotient bit per cycle; lo=quotient, hi=remainder; c=v=0.
REQ-025 DIV by zero: lo = all ones, hi = operand1, err=1, latency 1.
REQ-026 Illegal opcode: hi=lo=0, err=1, other flags 0.
REQ-027 z = (hi==0 && lo==0); n = MSB of hi for MUL, else MSB of lo; err=0 except REQ-025/026.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, out_valid=0, result_hi=result_lo=0, status_out=0, iteration counter=0.
REQ-029 Reset mid-BUSY or mid-DONE SHALL abort the operation; no result is presented after release.
REQ-030 in_ready SHALL be 1 during reset and the first cycle after release.

Structure
REQ-031 Package seq_alu_pkg SHALL hold opcode encodings, state encoding, and status bit indices (STAT_C=0..STAT_ERR=4).
REQ-032 Iterative MUL/DIV datapath and counter SHALL be one sub-module seq_alu_muldiv (start, op, a, b -> done, hi, lo); ADD/SUB/SHIFT stay in seq_alu.

Verification (WIDTH=8)
REQ-033 ADD 0xFF+0x01, carry_in 0 -> lo 0x00, hi 0x00, c=1, z=1, out_valid cycle after accept.
REQ-034 SUB 0x80-0x01, carry_in 0 -> lo 0x7F, v=1, c=0, n=0.
REQ-035 MUL 0xFF*0xFF -> hi 0xFE, lo 0x01, c=1; in_ready low 8 cycles, out_valid on 9th edge after accept.
REQ-036 DIV 100/7 -> lo 14, hi 2, latency 9; DIV 5/0 -> lo 0xFF, hi 0x05, err=1, latency 1.
REQ-037 SHIFT 0x81 by 0x01 -> 0x40; by 0xFF -> 0x02; by 0xF8 -> 0x00; opcode 111 -> err=1, result 0.
REQ-038 Hold out_ready low 5 cycles after a MUL -> outputs stable, in_ready 0; separately assert rst_n low at MUL iteration 3 -> out_valid 0, in_ready 1, no result after release.
